barrel_shifter_pipe: RTL and testbench
======================================

# barrel_shifter_pipe

Parametrised, pipelined barrel shifter, the successor to the 8-bit combinational right-rotator. It supports rotate, logical shift and arithmetic shift in either direction. Data moves through one registered stage per shift-amount bit, with valid/ready handshakes on both sides. It sits between a producer and a consumer that may each stall, and replaces the combinational rotator wherever timing or a wider datapath requires it.

## Interface
- DWIDTH, 32: data width. Must be a power of two and ≥ 2.
- KWIDTH, $clog2(DWIDTH): shift-amount width. Derived; do not override.
- NSTAGE, KWIDTH: number of pipeline stages. Derived; do not override.

- i_clk  in  1  clock. All state is updated on its rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_valid  in  1  input vector valid.
- o_ready  out  1  block accepts an input this cycle.
- i_a  in  DWIDTH  operand.
- i_k  in  KWIDTH  shift amount, 0..DWIDTH-1.
- i_mode  in  3  operation: 000 ROR, 001 ROL, 010 SRL, 011 SLL, 100 SRA. Codes 101–111 are reserved and behave as pass-through.
- o_valid  out  1  o_y is valid.
- i_ready  in  1  downstream accepts o_y this cycle.
- o_y  out  DWIDTH  result.
- o_busy  out  1  OR of all stage valid bits.

## Operation
- Stage s (0..NSTAGE-1) holds data, the remaining shift bits, mode and a valid bit.
- If k[s] = 1, stage s applies a shift of 2^s to the data from the previous stage (or from i_a for s = 0). If k[s] = 0, the data passes unchanged.
- Per-stage operation by mode:
  - ROR: bits wrap from LSB to MSB.
  - ROL: bits wrap from MSB to LSB.
  - SRL: zero-fill from the top.
  - SLL: zero-fill from the bottom.
  - SRA: fill with the original MSB of i_a.
  - Reserved codes: no shift.
- Results equal the single-step operation by i_k:
  - ROR(a,k) = (a >> k) | (a << (DWIDTH-k)).
  - k = 0 returns a unchanged in every mode.
- Arithmetic is unsigned except for SRA sign-fill. No overflow or carry output.
- Handshakes:
  - Input transfer: i_valid & o_ready. Output transfer: o_valid & i_ready.
  - Stage s loads when it is empty, or when its contents advance that cycle.
  - The last stage advances on i_ready.
  - o_ready is stage 0's load condition.
  - Bubbles collapse: an empty stage accepts data even while later stages are stalled.
- No vector is dropped, duplicated or reordered.
- o_valid and o_y are driven directly from the last stage's registers.
- While a stage is stalled, its data is held stable. o_y is stable while o_valid & !i_ready.

## Timing
- Reset: all valid bits, stage data and o_y clear to 0 immediately, without waiting for a clock edge.
  - Outputs during reset: o_valid = 0, o_busy = 0, o_ready = 1.
  - In-flight vectors are discarded. The first input accepted after reset release is the first output produced.
- Latency: an input accepted at edge t appears with o_valid = 1 after edge t+NSTAGE-1, when there are no stalls.
  - DWIDTH = 8: 3 edges. DWIDTH = 32: 5 edges.
- Throughput: one vector per cycle while i_ready = 1.
- Stall sequence with i_ready held at 0: o_ready drops only after all NSTAGE stages are valid.
  - o_ready returns to 1 in the same cycle that i_ready rises, because o_ready is combinational from i_ready through the stage chain.
- Simultaneous input and output transfer on a full pipe: legal. Occupancy is unchanged.
- Out-of-range control values cannot occur: i_k is KWIDTH wide. Reserved i_mode values pass data through.

## Test plan
All scenarios use DWIDTH = 8 unless noted.
- Mode sweep, i_a = 0xB4:
  - ROR k=3 → 0x96. ROL k=3 → 0xA5.
  - SRL k=2 → 0x2D. SLL k=2 → 0xD0. SRA k=2 → 0xED.
  - Mode 110 with k=5 → 0xB4.
  - Every mode with k=0 → 0xB4.
  - Each result has o_valid after 3 edges.
- Streaming: 8 back-to-back ROR vectors with i_ready = 1.
  - Outputs appear on 8 consecutive cycles, in order. o_ready stays 1.
- Backpressure: stream vectors with i_ready = 0 for 6 cycles.
  - o_ready falls once 3 stages are full.
  - o_y stays constant.
  - After i_ready rises, all vectors emerge in order with no loss.
- Bubble collapse: with i_ready = 0 and only stage 2 full, present 2 vectors.
  - Both are accepted (o_ready = 1), then o_ready falls.
- Reset mid-operation: assert i_rst asynchronously between edges with 2 vectors in flight.
  - o_valid, o_busy and o_y go to 0 before the next edge.
  - After release, only post-reset inputs emerge.
- Random scoreboard: 1000 random {i_a, i_k, i_mode} vectors with random i_valid/i_ready, at DWIDTH = 8 and DWIDTH = 32.
  - Zero mismatches against a reference model. Counts in and out are equal.

Source files
------------

// File: rtl/barrel_shifter_pipe_if.sv
// Stream interface of the pipelined barrel shifter: operand/control in, result out.
// A word moves on a side in any cycle where that side's valid and ready are both high at the clock edge.
interface barrel_shifter_pipe_if #(
    parameter int DWIDTH = 32
);
    localparam int KWIDTH = $clog2(DWIDTH);

    logic              i_valid;
    logic              o_ready;
    logic [DWIDTH-1:0] i_a;
    logic [KWIDTH-1:0] i_k;
    logic [2:0]        i_mode;
    logic              o_valid;
    logic              i_ready;
    logic [DWIDTH-1:0] o_y;
    logic              o_busy;

    modport master (
        output i_valid, i_a, i_k, i_mode, i_ready,
        input  o_ready, o_valid, o_y, o_busy
    );

    modport slave (
        input  i_valid, i_a, i_k, i_mode, i_ready,
        output o_ready, o_valid, o_y, o_busy
    );
endinterface

// File: rtl/barrel_shifter_pipe.sv
// Pipelined rotate/shift unit: stage s conditionally shifts by 2^s under control of k[s].
// Elastic valid/ready chain per stage, so bubbles collapse while the output is stalled.
module barrel_shifter_pipe #(
    parameter int DWIDTH = 32
) (
    input logic                  i_clk,
    input logic                  i_rst,
    barrel_shifter_pipe_if.slave io
);
    localparam int KWIDTH = $clog2(DWIDTH);
    localparam int NSTAGE = KWIDTH;

    localparam logic [2:0] MODE_ROR = 3'b000;
    localparam logic [2:0] MODE_ROL = 3'b001;
    localparam logic [2:0] MODE_SRL = 3'b010;
    localparam logic [2:0] MODE_SLL = 3'b011;
    localparam logic [2:0] MODE_SRA = 3'b100;

    // sh is always a constant 2^s below DWIDTH, so every branch is plain wiring.
    function automatic logic [DWIDTH-1:0] shift_step(
        input logic [DWIDTH-1:0] d,
        input logic [2:0]        m,
        input int unsigned       sh
    );
        logic [DWIDTH-1:0] r;
        case (m)
            MODE_ROR: r = (d >> sh) | (d << (DWIDTH - sh));
            MODE_ROL: r = (d << sh) | (d >> (DWIDTH - sh));
            MODE_SRL: r = d >> sh;
            MODE_SLL: r = d << sh;
            MODE_SRA: r = $unsigned($signed(d) >>> sh);
            default:  r = d;
        endcase
        return r;
    endfunction

    logic [NSTAGE-1:0] v_all;

    for (genvar s = 0; s < NSTAGE; s++) begin : g_stage
        localparam int          KW = KWIDTH - s;
        localparam int unsigned SH = 1 << s;

        logic              v_in;
        logic [DWIDTH-1:0] d_in;
        logic [KW-1:0]     k_in;
        logic [2:0]        m_in;
        logic              v_q;
        logic [DWIDTH-1:0] d_q;
        logic              ld;
        logic              adv;

        if (s == 0) begin : g_src
            assign v_in = io.i_valid;
            assign d_in = io.i_a;
            assign k_in = io.i_k;
            assign m_in = io.i_mode;
        end else begin : g_src
            assign v_in = g_stage[s-1].v_q;
            assign d_in = g_stage[s-1].d_q;
            assign k_in = g_stage[s-1].g_ctrl.k_q;
            assign m_in = g_stage[s-1].g_ctrl.m_q;
        end

        if (s == NSTAGE - 1) begin : g_sink
            assign adv = v_q & io.i_ready;
        end else begin : g_sink
            assign adv = v_q & g_stage[s+1].ld;
        end

        assign ld = ~v_q | adv;

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                v_q <= 1'b0;
                d_q <= '0;
            end else if (ld) begin
                v_q <= v_in;
                if (v_in) begin
                    d_q <= k_in[0] ? shift_step(d_in, m_in, SH) : d_in;
                end
            end
        end

        // Only the not-yet-consumed shift bits travel on; the last stage needs no control.
        if (s < NSTAGE - 1) begin : g_ctrl
            logic [KW-2:0] k_q;
            logic [2:0]    m_q;

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    k_q <= '0;
                    m_q <= '0;
                end else if (ld && v_in) begin
                    k_q <= k_in[KW-1:1];
                    m_q <= m_in;
                end
            end
        end

        assign v_all[s] = v_q;
    end

    assign io.o_ready = g_stage[0].ld;
    assign io.o_valid = g_stage[NSTAGE-1].v_q;
    assign io.o_y     = g_stage[NSTAGE-1].d_q;
    assign io.o_busy  = |v_all;
endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Bench for barrel_shifter_pipe: directed latency/stall/reset vectors at DWIDTH=8,
// then random traffic against a reference model at DWIDTH=8 and DWIDTH=32.
module tb_barrel_shifter_pipe;
    logic clk;
    logic rst;

    barrel_shifter_pipe_if #(.DWIDTH(8))  b8 ();
    barrel_shifter_pipe_if #(.DWIDTH(32)) b32 ();

    barrel_shifter_pipe #(.DWIDTH(8))  dut8  (.i_clk(clk), .i_rst(rst), .io(b8));
    barrel_shifter_pipe #(.DWIDTH(32)) dut32 (.i_clk(clk), .i_rst(rst), .io(b32));

    int n_vec = 0;
    int n_err = 0;
    int in8 = 0, out8 = 0, in32 = 0, out32 = 0;
    logic sb_en = 1'b0;
    logic [31:0] exp8_q[$];
    logic [31:0] exp32_q[$];

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [31:0] a, input int k,
                                           input logic [2:0] m, input int w);
        logic [31:0] mask, x, r;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        x = a & mask;
        case (m)
            3'd0: r = (x >> k) | (x << (w - k));
            3'd1: r = (x << k) | (x >> (w - k));
            3'd2: r = x >> k;
            3'd3: r = x << k;
            3'd4: begin
                r = x >> k;
                if (x[w-1]) r = r | (mask & ~(mask >> k));
            end
            default: r = x;
        endcase
        return r & mask;
    endfunction

    // scoreboards
    always @(negedge clk) begin
        if (sb_en && !rst) begin
            if (b8.o_valid && b8.i_ready) begin
                check_val("sb8_nonempty", 32'(exp8_q.size() != 0), 32'd1);
                if (exp8_q.size() != 0) check_val("sb8_y", 32'(b8.o_y), exp8_q.pop_front());
                out8++;
            end
            if (b8.i_valid && b8.o_ready) begin
                exp8_q.push_back(ref_op(32'(b8.i_a), int'(b8.i_k), b8.i_mode, 8));
                in8++;
            end
        end
    end

    always @(negedge clk) begin
        if (sb_en && !rst) begin
            if (b32.o_valid && b32.i_ready) begin
                check_val("sb32_nonempty", 32'(exp32_q.size() != 0), 32'd1);
                if (exp32_q.size() != 0) check_val("sb32_y", b32.o_y, exp32_q.pop_front());
                out32++;
            end
            if (b32.i_valid && b32.o_ready) begin
                exp32_q.push_back(ref_op(b32.i_a, int'(b32.i_k), b32.i_mode, 32));
                in32++;
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive8(input logic [7:0] a, input logic [2:0] k, input logic [2:0] m);
        b8.i_valid = 1'b1;
        b8.i_a     = a;
        b8.i_k     = k;
        b8.i_mode  = m;
    endtask

    task automatic run_vec(input string tag, input logic [7:0] a, input logic [2:0] k,
                           input logic [2:0] m, input logic [7:0] exp);
        tick();
        b8.i_ready = 1'b1;
        drive8(a, k, m);
        tick();
        b8.i_valid = 1'b0;
        tick();
        check_val({tag, "_early"}, 32'(b8.o_valid), 32'd0);
        tick();
        check_val({tag, "_valid"}, 32'(b8.o_valid), 32'd1);
        check_val({tag, "_y"}, 32'(b8.o_y), 32'(exp));
    endtask

    task automatic drive_rand8(input int n);
        int sent = 0;
        int cyc = 0;
        logic pend = 1'b0;
        while (sent < n && cyc < 20000) begin
            if (!pend) begin
                b8.i_a     = 8'($urandom);
                b8.i_k     = 3'($urandom_range(0, 7));
                b8.i_mode  = 3'($urandom_range(0, 7));
                b8.i_valid = ($urandom_range(0, 3) != 0);
            end
            b8.i_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (b8.i_valid && b8.o_ready) begin
                sent++;
                pend = 1'b0;
            end else begin
                pend = b8.i_valid;
            end
            tick();
            cyc++;
        end
        b8.i_valid = 1'b0;
        b8.i_ready = 1'b1;
        check_val("rand8_sent", 32'(sent), 32'(n));
    endtask

    task automatic drive_rand32(input int n);
        int sent = 0;
        int cyc = 0;
        logic pend = 1'b0;
        while (sent < n && cyc < 20000) begin
            if (!pend) begin
                b32.i_a     = $urandom;
                b32.i_k     = 5'($urandom_range(0, 31));
                b32.i_mode  = 3'($urandom_range(0, 7));
                b32.i_valid = ($urandom_range(0, 3) != 0);
            end
            b32.i_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (b32.i_valid && b32.o_ready) begin
                sent++;
                pend = 1'b0;
            end else begin
                pend = b32.i_valid;
            end
            tick();
            cyc++;
        end
        b32.i_valid = 1'b0;
        b32.i_ready = 1'b1;
        check_val("rand32_sent", 32'(sent), 32'(n));
    endtask

    logic [7:0] st_a[8]   = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    logic [7:0] st_exp[8] = '{8'h80, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};

    initial begin
        rst = 1'b1;
        b8.i_valid = 1'b0;  b8.i_a = '0;  b8.i_k = '0;  b8.i_mode = '0;  b8.i_ready = 1'b1;
        b32.i_valid = 1'b0; b32.i_a = '0; b32.i_k = '0; b32.i_mode = '0; b32.i_ready = 1'b1;
        repeat (2) tick();
        check_val("rst_valid", 32'(b8.o_valid), 32'd0);
        check_val("rst_busy", 32'(b8.o_busy), 32'd0);
        check_val("rst_ready", 32'(b8.o_ready), 32'd1);
        check_val("rst_y", 32'(b8.o_y), 32'd0);
        check_val("rst32_ready", 32'(b32.o_ready), 32'd1);
        rst = 1'b0;

        // mode sweep on 0xB4
        run_vec("ror3", 8'hB4, 3'd3, 3'b000, 8'h96);
        run_vec("rol3", 8'hB4, 3'd3, 3'b001, 8'hA5);
        run_vec("srl2", 8'hB4, 3'd2, 3'b010, 8'h2D);
        run_vec("sll2", 8'hB4, 3'd2, 3'b011, 8'hD0);
        run_vec("sra2", 8'hB4, 3'd2, 3'b100, 8'hED);
        run_vec("rsv6", 8'hB4, 3'd5, 3'b110, 8'hB4);
        for (int m = 0; m < 8; m++) begin
            run_vec($sformatf("k0_m%0d", m), 8'hB4, 3'd0, 3'(m), 8'hB4);
        end
        run_vec("ror7", 8'hB4, 3'd7, 3'b000, 8'h69);
        run_vec("srl7", 8'hB4, 3'd7, 3'b010, 8'h01);
        run_vec("sra7", 8'hB4, 3'd7, 3'b100, 8'hFF);
        tick();

        // back-to-back stream, ROR by 1
        b8.i_ready = 1'b1;
        for (int c = 0; c < 11; c++) begin
            if (c < 8) drive8(st_a[c], 3'd1, 3'b000);
            else b8.i_valid = 1'b0;
            #1;
            if (c < 8) check_val($sformatf("st_rdy%0d", c), 32'(b8.o_ready), 32'd1);
            if (c >= 3) begin
                check_val($sformatf("st_v%0d", c - 3), 32'(b8.o_valid), 32'd1);
                check_val($sformatf("st_y%0d", c - 3), 32'(b8.o_y), 32'(st_exp[c-3]));
            end
            tick();
        end
        check_val("st_end", 32'(b8.o_valid), 32'd0);

        // backpressure for 6 cycles
        b8.i_ready = 1'b0;
        drive8(8'h0F, 3'd4, 3'b001); #1; check_val("bp_rdy0", 32'(b8.o_ready), 32'd1); tick();
        drive8(8'hF0, 3'd4, 3'b010); #1; check_val("bp_rdy1", 32'(b8.o_ready), 32'd1); tick();
        drive8(8'h90, 3'd2, 3'b100); #1; check_val("bp_rdy2", 32'(b8.o_ready), 32'd1); tick();
        drive8(8'h3C, 3'd1, 3'b000);
        for (int c = 0; c < 3; c++) begin
            #1;
            check_val("bp_full_rdy", 32'(b8.o_ready), 32'd0);
            check_val("bp_hold_v", 32'(b8.o_valid), 32'd1);
            check_val("bp_hold_y", 32'(b8.o_y), 32'hF0);
            tick();
        end
        b8.i_ready = 1'b1;
        #1; check_val("bp_rdy_rise", 32'(b8.o_ready), 32'd1);
        tick();
        b8.i_valid = 1'b0;
        check_val("bp_y1", 32'(b8.o_y), 32'h0F); tick();
        check_val("bp_y2", 32'(b8.o_y), 32'hE4); tick();
        check_val("bp_y3", 32'(b8.o_y), 32'h1E); tick();
        check_val("bp_end", 32'(b8.o_valid), 32'd0);

        // bubble collapse behind a stalled last stage
        b8.i_ready = 1'b0;
        drive8(8'h01, 3'd7, 3'b011); tick();
        b8.i_valid = 1'b0; tick();
        tick();
        check_val("bub_only_s2", 32'(b8.o_busy & b8.o_valid), 32'd1);
        drive8(8'hC3, 3'd1, 3'b001); #1; check_val("bub_rdy_a", 32'(b8.o_ready), 32'd1); tick();
        drive8(8'h55, 3'd3, 3'b111); #1; check_val("bub_rdy_b", 32'(b8.o_ready), 32'd1); tick();
        b8.i_valid = 1'b0;
        #1; check_val("bub_full", 32'(b8.o_ready), 32'd0);
        check_val("bub_y0", 32'(b8.o_y), 32'h80);
        b8.i_ready = 1'b1;
        tick(); check_val("bub_y1", 32'(b8.o_y), 32'h87);
        tick(); check_val("bub_y2", 32'(b8.o_y), 32'h55);
        tick(); check_val("bub_end", 32'(b8.o_valid), 32'd0);

        // asynchronous reset with two vectors in flight
        drive8(8'h0F, 3'd4, 3'b000); tick();
        drive8(8'h01, 3'd1, 3'b011); tick();
        b8.i_valid = 1'b0; tick();
        check_val("ar_pre_v", 32'(b8.o_valid), 32'd1);
        check_val("ar_pre_y", 32'(b8.o_y), 32'hF0);
        #2 rst = 1'b1;
        #1;
        check_val("ar_valid", 32'(b8.o_valid), 32'd0);
        check_val("ar_busy", 32'(b8.o_busy), 32'd0);
        check_val("ar_y", 32'(b8.o_y), 32'd0);
        check_val("ar_ready", 32'(b8.o_ready), 32'd1);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check_val("ar_quiet", 32'(b8.o_busy | b8.o_valid), 32'd0);
        run_vec("ar_post", 8'h33, 3'd1, 3'b001, 8'h66);
        tick();
        check_val("ar_only_post", 32'(b8.o_valid), 32'd0);

        // random traffic on both widths
        sb_en = 1'b1;
        fork
            drive_rand8(1000);
            drive_rand32(1000);
        join
        for (int c = 0; c < 50; c++) begin
            if (!b8.o_busy && !b32.o_busy) break;
            tick();
        end
        check_val("drain8_busy", 32'(b8.o_busy), 32'd0);
        check_val("drain32_busy", 32'(b32.o_busy), 32'd0);
        check_val("cnt8_io", 32'(out8), 32'(in8));
        check_val("cnt32_io", 32'(out32), 32'(in32));
        check_val("q8_empty", 32'(exp8_q.size()), 32'd0);
        check_val("q32_empty", 32'(exp32_q.size()), 32'd0);
        sb_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
